// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte/half/word load-store initiator for the word-wide data memory
// Optional MEM_ACCESS_CNT_EN adds saturating load_cnt/store_cnt outputs.
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DM_IDX_W = 6
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic              op_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic [31:0]       M_W_Data,
    output logic              Mem_Write,
    input  logic [31:0]       M_R_Data
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       load_cnt,
    output logic [15:0]       store_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wlo_q, wlo_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              acc_err;
    logic              addr_hi_bad;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign addr_hi_bad = (addr >> (DM_IDX_W + 2)) != '0;

    always_comb begin
        acc_err = addr_hi_bad;
        case (size)
            2'b00:   acc_err = addr_hi_bad;
            2'b01:   acc_err = addr_hi_bad | addr[0];
            2'b10:   acc_err = addr_hi_bad | (addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
    end

    // Lane extraction and merge both work off the latched low address bits.
    assign byte_sel = 8'(M_R_Data >> {addr_q[1:0], 3'b000});
    assign half_sel = 16'(M_R_Data >> {addr_q[1], 4'b0000});

    always_comb begin
        load_val = M_R_Data;
        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
            default: load_val = M_R_Data;
        endcase
    end

    always_comb begin
        merged = M_R_Data;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wlo_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wlo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wlo_d   = wlo_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d   = op_write;
                    size_d = size;
                    sext_d = sign_ext;
                    addr_d = addr;
                    wlo_d  = wdata[15:0];
                    if (acc_err) begin
                        state_d = S_ERR;
                    end else if (!op_write) begin
                        state_d = S_LOAD;
                    end else if (size == 2'b10) begin
                        wbuf_d  = wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_val;
                state_d = S_DONE;
            end
            S_MERGE: begin
                wbuf_d  = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wlo_q   <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wlo_q   <= wlo_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode straight from the state register, so reset kills Mem_Write at once.
    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);
    assign Mem_Write = (state_q == S_WRITE);
    assign DM_Addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign M_W_Data  = wbuf_q;
    assign rdata     = rdata_q;

`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;

    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (state_q == S_DONE) begin
            if (!op_q && load_cnt_q != 16'hFFFF) begin
                load_cnt_d = load_cnt_q + 16'd1;
            end
            if (op_q && store_cnt_q != 16'hFFFF) begin
                store_cnt_d = store_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl against a behavioural DM model
module tb_mem_access_ctrl;

    localparam int ADDR_W    = 32;
    localparam int DM_IDX_W  = 6;
    localparam int ADDR_LIM  = 1 << (DM_IDX_W + 2);

    logic              clk_dm = 1'b0;
    logic              rst_n;
    logic              req;
    logic              ready;
    logic              op_write;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] DM_Addr;
    logic [31:0]       M_W_Data;
    logic              Mem_Write;
    logic [31:0]       M_R_Data;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0]       load_cnt;
    logic [15:0]       store_cnt;
`endif

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DM_IDX_W(DM_IDX_W)) dut (
        .clk_dm    (clk_dm),
        .rst_n     (rst_n),
        .req       (req),
        .ready     (ready),
        .op_write  (op_write),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .DM_Addr   (DM_Addr),
        .M_W_Data  (M_W_Data),
        .Mem_Write (Mem_Write),
        .M_R_Data  (M_R_Data)
`ifdef MEM_ACCESS_CNT_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
`endif
    );

    always #5 clk_dm = ~clk_dm;

    // Data memory instance seen by the DUT, plus the bench's own shadow of it.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    assign M_R_Data = mem[DM_Addr[7:2]];
    always @(posedge clk_dm) begin
        if (Mem_Write) mem[DM_Addr[7:2]] <= M_W_Data;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = 32'h0;
    int          exp_ld = 0;
    int          exp_st = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input logic [1:0] sz, input logic sx);
        longint v;
        if (sz == 2'b00) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (sx && v >= 128) v = v - 256;
        end else if (sz == 2'b01) begin
            v = (w >> (8 * off)) & 32'hFFFF;
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input int off,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        if (sz == 2'b00)      mask = 32'hFF << (8 * off);
        else if (sz == 2'b01) mask = 32'hFFFF << (8 * off);
        else                  mask = 32'hFFFF_FFFF;
        return (old & ~mask) | ((wd << (8 * off)) & mask);
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
               (sz == 2'b10 && a % 4 != 0) || (a >= ADDR_LIM);
    endfunction

    // Entered and left on a negedge with the DUT idle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          e;
        int          lat;
        int          nwr;
        int          exp_lat;
        int          guard;
        int          idx;
        int          off;
        logic [31:0] new_word;
        e        = ref_err(sz, a);
        idx      = int'(a[7:2]);
        off      = int'(a[1:0]);
        new_word = ref_store(ref_mem[idx], off, sz, wd);
        exp_lat  = e ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
        guard = 0;
        while (!ready && guard < 10) begin
            @(negedge clk_dm);
            guard++;
        end
        check("ready_before_req", {31'b0, ready}, 32'd1);
        req = 1'b1; op_write = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk_dm);
        @(negedge clk_dm);
        req = 1'b0;
        wdata = $urandom;
        lat = 1;
        nwr = 0;
        while (!done && lat < 8) begin
            check("ready_busy", {31'b0, ready}, 32'd0);
            if (Mem_Write) begin
                nwr++;
                check("wr_addr", DM_Addr, {a[31:2], 2'b00});
                check("wr_data", M_W_Data, new_word);
            end
            @(negedge clk_dm);
            lat++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("latency", lat, exp_lat);
        check("err", {31'b0, err}, {31'b0, e});
        check("we_count", nwr, (!e && w) ? 1 : 0);
        check("we_in_done", {31'b0, Mem_Write}, 32'd0);
        check("ready_in_done", {31'b0, ready}, 32'd0);
        if (!e && !w) begin
            exp_rdata = ref_load(ref_mem[idx], off, sz, sx);
            exp_ld++;
        end
        if (!e && w) begin
            ref_mem[idx] = new_word;
            exp_st++;
        end
        check("rdata", rdata, exp_rdata);
        if (!e && w) check("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clk_dm);
        check("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int readys;
        logic [31:0] saved;
        logic [31:0] a;
        rst_n = 1'b0; req = 1'b0; op_write = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        #1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_we", {31'b0, Mem_Write}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_dm_addr", DM_Addr, 32'h0);
        check("rst_wdata", M_W_Data, 32'h0);
        @(negedge clk_dm);
        @(negedge clk_dm);
        rst_n = 1'b1;
        @(negedge clk_dm);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("tc_word_store", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("tc_lb_sext", rdata, 32'hFFFFFFDE);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("tc_lb_zext", rdata, 32'h000000DE);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234);
        check("tc_half_store", mem[4], 32'h1234BEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        check("tc_err_rdata", rdata, 32'h000000DE);
        do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        check("tc_range_rdata", rdata, 32'h000000DE);
        do_req(1'b0, 2'b00, 1'b1, ADDR_LIM - 1, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, ADDR_LIM - 1, 32'hA5);

        // Abort a word store while it is in WRITE.
        saved = mem[8];
        req = 1'b1; op_write = 1'b1; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h20; wdata = 32'hCAFEF00D;
        @(posedge clk_dm);
        @(negedge clk_dm);
        req = 1'b0;
        check("abort_we_pre", {31'b0, Mem_Write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'b0, Mem_Write}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);
        @(posedge clk_dm);
        #1;
        check("abort_mem", mem[8], saved);
        check("abort_ref", mem[8], ref_mem[8]);
        @(negedge clk_dm);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        exp_ld = 0;
        exp_st = 0;
        check("abort_rdata", rdata, 32'h0);
        @(negedge clk_dm);

        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h77);
        do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h44, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'h13572468);
        do_req(1'b0, 2'b00, 1'b0, 32'h45, 32'h0);
`ifdef MEM_ACCESS_CNT_EN
        check("cnt_load", {16'b0, load_cnt}, 32'd3);
        check("cnt_store", {16'b0, store_cnt}, 32'd2);
`endif

        // req held high: loads repeat every three cycles.
        dones = 0;
        readys = 0;
        req = 1'b1; op_write = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h06;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_dm);
            @(negedge clk_dm);
            if (done) dones++;
            if (ready) readys++;
        end
        req = 1'b0;
        exp_rdata = ref_load(ref_mem[1], 2, 2'b00, 1'b0);
        exp_ld += 10;
        check("held_dones", dones, 32'd10);
        check("held_readys", readys, 32'd10);
        check("held_rdata", rdata, exp_rdata);
        @(negedge clk_dm);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h100;
            else a = $urandom_range(0, ADDR_LIM - 1);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);
`ifdef MEM_ACCESS_CNT_EN
        check("final_load_cnt", {16'b0, load_cnt}, exp_ld);
        check("final_store_cnt", {16'b0, store_cnt}, exp_st);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
